hazard_ctrl: RTL and testbench

Stall and multiply/divide scheduling controller for the 5-stage MIPS pipeline.
- Compares D-stage register uses against E/M-stage pending writes using Tuse/Tnew encoding.
- Tracks the multi-cycle mult/div unit's busy window.
- Drives the enables of the PC and F/D register and the clear of the D/E register.
- Sits beside the pipeline registers; it contains no datapath and only controls when they advance or take a bubble.

---
 rtl/hazard_pkg.sv | 30 +++
 rtl/hazard_ctrl_if.sv | 30 +++
 rtl/md_busy_timer.sv | 70 +++++++
 rtl/hazard_ctrl.sv | 65 ++++++
 tb/tb_hazard_ctrl.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard/stall controller: Tuse/Tnew timing codes,
// mult/div start codes, default unit latencies and the busy-timer state type.
package hazard_pkg;

  // Tuse: cycles from D until the operand is consumed
  localparam logic [1:0] TUSE_D = 2'd0;
  localparam logic [1:0] TUSE_E = 2'd1;
  localparam logic [1:0] TUSE_M = 2'd2;

  // Tnew: cycles until a pending result can be forwarded
  localparam logic [1:0] TNEW_0 = 2'd0;
  localparam logic [1:0] TNEW_1 = 2'd1;
  localparam logic [1:0] TNEW_2 = 2'd2;

  // mult/div start codes seen in E; 2'b11 is treated as no start
  localparam logic [1:0] MD_NONE = 2'b00;
  localparam logic [1:0] MD_MULT = 2'b01;
  localparam logic [1:0] MD_DIV  = 2'b10;

  localparam int MULT_CYC_DEF = 5;
  localparam int DIV_CYC_DEF  = 10;

  typedef enum logic {MD_IDLE = 1'b0, MD_BUSY = 1'b1} md_state_e;

  // Only mult and div launch the unit; anything else is ignored
  function automatic logic md_start_valid(input logic [1:0] code);
    return (code == MD_MULT) || (code == MD_DIV);
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side bundle of the hazard controller: D/E/M stage register
// information in, pipeline enables/bubble control and status out.
interface hazard_ctrl_if;
  logic [4:0]  rs_D, rt_D;
  logic        use_rs_D, use_rt_D;
  logic [1:0]  tuse_rs_D, tuse_rt_D;
  logic [4:0]  a3_E, a3_M;
  logic [1:0]  tnew_E, tnew_M;
  logic        md_D;
  logic [1:0]  md_start_E;
  logic        en_PC, en_FD, clr_DE, stall;
  logic        md_busy;
  logic [3:0]  md_cnt;
  logic [31:0] stall_cnt;
  logic        md_err;

  // Pipeline side: supplies stage info, consumes controls
  modport master (
    output rs_D, rt_D, use_rs_D, use_rt_D, tuse_rs_D, tuse_rt_D,
           a3_E, a3_M, tnew_E, tnew_M, md_D, md_start_E,
    input  en_PC, en_FD, clr_DE, stall, md_busy, md_cnt, stall_cnt, md_err
  );

  // Controller side
  modport slave (
    input  rs_D, rt_D, use_rs_D, use_rt_D, tuse_rs_D, tuse_rt_D,
           a3_E, a3_M, tnew_E, tnew_M, md_D, md_start_E,
    output en_PC, en_FD, clr_DE, stall, md_busy, md_cnt, stall_cnt, md_err
  );
endinterface

// File: rtl/md_busy_timer.sv
// Busy window of the multi-cycle mult/div unit. A start in E loads the
// unit latency; the counter runs down to zero and the unit frees up.
// Starts arriving while busy are dropped and latch a sticky error.
module md_busy_timer
  import hazard_pkg::*;
#(
  parameter int MULT_CYC = MULT_CYC_DEF,
  parameter int DIV_CYC  = DIV_CYC_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] md_start_E,
  output logic       md_busy,
  output logic [3:0] md_cnt,
  output logic       md_err
);

  md_state_e  state, state_nxt;
  logic [3:0] cnt_nxt;
  logic       err_nxt;
  logic       start_ok;

  assign start_ok = md_start_valid(md_start_E);
  assign md_busy  = (state == MD_BUSY);

  // State, counter and sticky error registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= MD_IDLE;
      md_cnt <= 4'd0;
      md_err <= 1'b0;
    end else begin
      state  <= state_nxt;
      md_cnt <= cnt_nxt;
      md_err <= err_nxt;
    end
  end

  // Next state: load on start when idle, count down when busy
  always_comb begin
    state_nxt = state;
    cnt_nxt   = md_cnt;
    err_nxt   = md_err;
    case (state)
      MD_IDLE: begin
        if (md_start_E == MD_MULT) begin
          state_nxt = MD_BUSY;
          cnt_nxt   = 4'(MULT_CYC);
        end else if (md_start_E == MD_DIV) begin
          state_nxt = MD_BUSY;
          cnt_nxt   = 4'(DIV_CYC);
        end
      end
      MD_BUSY: begin
        if (start_ok) err_nxt = 1'b1;
        if (md_cnt == 4'd1) begin
          state_nxt = MD_IDLE;
          cnt_nxt   = 4'd0;
        end else begin
          cnt_nxt   = md_cnt - 4'd1;
        end
      end
      default: begin
        state_nxt = MD_IDLE;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall controller for the 5-stage pipeline. Compares D-stage sources
// against E/M pending writes with Tuse/Tnew, adds the mult/div busy stall,
// and freezes PC/F-D while bubbling D-E. No datapath lives here.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MULT_CYC = MULT_CYC_DEF,
  parameter int DIV_CYC  = DIV_CYC_DEF
) (
  input logic         clk,
  input logic         reset,
  hazard_ctrl_if.slave hz
);

  logic        rs_hit, rt_hit, md_stall, stall;
  logic        md_busy, md_err;
  logic [3:0]  md_cnt;
  logic [31:0] stall_cnt;

  // A source is hazardous when a younger write will not be ready in time;
  // register zero is hardwired and never waits
  function automatic logic src_hazard(
    input logic       use_src, input logic [4:0] src, input logic [1:0] tuse,
    input logic [4:0] a3_e, input logic [1:0] tnew_e,
    input logic [4:0] a3_m, input logic [1:0] tnew_m);
    return use_src && (src != 5'd0) &&
           (((src == a3_e) && (tnew_e > tuse)) ||
            ((src == a3_m) && (tnew_m > tuse)));
  endfunction

  md_busy_timer #(.MULT_CYC(MULT_CYC), .DIV_CYC(DIV_CYC)) u_md (
    .clk        (clk),
    .reset      (reset),
    .md_start_E (hz.md_start_E),
    .md_busy    (md_busy),
    .md_cnt     (md_cnt),
    .md_err     (md_err)
  );

  // Zero-latency stall decision from current inputs and timer state
  always_comb begin
    rs_hit   = src_hazard(hz.use_rs_D, hz.rs_D, hz.tuse_rs_D,
                          hz.a3_E, hz.tnew_E, hz.a3_M, hz.tnew_M);
    rt_hit   = src_hazard(hz.use_rt_D, hz.rt_D, hz.tuse_rt_D,
                          hz.a3_E, hz.tnew_E, hz.a3_M, hz.tnew_M);
    md_stall = hz.md_D && (md_busy || md_start_valid(hz.md_start_E));
    stall    = rs_hit || rt_hit || md_stall;
  end

  // Saturating count of stalled cycles
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                          stall_cnt <= 32'd0;
    else if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + 32'd1;
  end

  assign hz.stall     = stall;
  assign hz.en_PC     = !stall;
  assign hz.en_FD     = !stall;
  assign hz.clr_DE    = stall;
  assign hz.md_busy   = md_busy;
  assign hz.md_cnt    = md_cnt;
  assign hz.md_err    = md_err;
  assign hz.stall_cnt = stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: data hazards, register zero, mult/div
// busy window, async reset mid-busy and the sticky start error.
module tb_hazard_ctrl;
  import hazard_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  hazard_ctrl_if hz ();

  hazard_ctrl #(.MULT_CYC(5), .DIV_CYC(10)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    hz.rs_D = 5'd0; hz.rt_D = 5'd0;
    hz.use_rs_D = 1'b0; hz.use_rt_D = 1'b0;
    hz.tuse_rs_D = 2'd0; hz.tuse_rt_D = 2'd0;
    hz.a3_E = 5'd0; hz.a3_M = 5'd0;
    hz.tnew_E = 2'd0; hz.tnew_M = 2'd0;
    hz.md_D = 1'b0; hz.md_start_E = MD_NONE;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    clear_inputs();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    clear_inputs();
    #12;
    checks++; if (hz.md_busy !== 1'b0) begin errors++; $display("FAIL rst_md_busy got %b exp 0", hz.md_busy); end
    checks++; if (hz.md_cnt !== 4'd0) begin errors++; $display("FAIL rst_md_cnt got %0d exp 0", hz.md_cnt); end
    checks++; if (hz.stall_cnt !== 32'd0) begin errors++; $display("FAIL rst_stall_cnt got %0d exp 0", hz.stall_cnt); end
    checks++; if (hz.md_err !== 1'b0) begin errors++; $display("FAIL rst_md_err got %b exp 0", hz.md_err); end
    checks++; if ({hz.stall, hz.en_PC, hz.en_FD, hz.clr_DE} !== 4'b0110) begin errors++; $display("FAIL rst_ctrl got %b exp 0110", {hz.stall, hz.en_PC, hz.en_FD, hz.clr_DE}); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_data_stall_e();
    do_reset();
    hz.rs_D = 5'd5; hz.use_rs_D = 1'b1; hz.tuse_rs_D = TUSE_D;
    hz.a3_E = 5'd5; hz.tnew_E = TNEW_1;
    #1;
    checks++; if ({hz.stall, hz.en_PC, hz.en_FD, hz.clr_DE} !== 4'b1001) begin errors++; $display("FAIL e_stall_ctrl got %b exp 1001", {hz.stall, hz.en_PC, hz.en_FD, hz.clr_DE}); end
    @(negedge clk);
    hz.a3_E = 5'd0;
    #1;
    checks++; if (hz.stall !== 1'b0) begin errors++; $display("FAIL e_clear got %b exp 0", hz.stall); end
    checks++; if (hz.stall_cnt !== 32'd1) begin errors++; $display("FAIL e_stall_cnt got %0d exp 1", hz.stall_cnt); end
    // tnew equal to tuse is forwardable in time
    hz.a3_E = 5'd5; hz.tnew_E = TNEW_0;
    #1;
    checks++; if (hz.stall !== 1'b0) begin errors++; $display("FAIL e_tnew_eq_tuse got %b exp 0", hz.stall); end
  endtask

  task automatic test_load_use();
    do_reset();
    hz.a3_M = 5'd8; hz.tnew_M = TNEW_1;
    hz.rt_D = 5'd8; hz.use_rt_D = 1'b1; hz.tuse_rt_D = TUSE_E;
    #1;
    checks++; if (hz.stall !== 1'b0) begin errors++; $display("FAIL lu_tuse1 got %b exp 0", hz.stall); end
    hz.tuse_rt_D = TUSE_D;
    #1;
    checks++; if (hz.stall !== 1'b1) begin errors++; $display("FAIL lu_tuse0 got %b exp 1", hz.stall); end
    hz.use_rt_D = 1'b0;
    #1;
    checks++; if (hz.stall !== 1'b0) begin errors++; $display("FAIL lu_unused got %b exp 0", hz.stall); end
    hz.use_rt_D = 1'b1; hz.rt_D = 5'd9;
    #1;
    checks++; if (hz.stall !== 1'b0) begin errors++; $display("FAIL lu_other_reg got %b exp 0", hz.stall); end
  endtask

  task automatic test_reg_zero();
    do_reset();
    hz.rs_D = 5'd0; hz.use_rs_D = 1'b1; hz.tuse_rs_D = TUSE_D;
    hz.a3_E = 5'd0; hz.tnew_E = TNEW_2;
    #1;
    checks++; if (hz.stall !== 1'b0) begin errors++; $display("FAIL zero_reg got %b exp 0", hz.stall); end
  endtask

  task automatic test_mult();
    do_reset();
    hz.md_D = 1'b1; hz.md_start_E = MD_MULT;
    #1;
    checks++; if ({hz.stall, hz.md_busy} !== 2'b10) begin errors++; $display("FAIL mult_start got %b exp 10", {hz.stall, hz.md_busy}); end
    for (int c = 5; c >= 1; c--) begin
      @(negedge clk);
      hz.md_start_E = MD_NONE;
      #1;
      checks++; if ({hz.md_busy, hz.md_cnt, hz.stall} !== {1'b1, 4'(c), 1'b1}) begin errors++; $display("FAIL mult_busy got busy=%b cnt=%0d stall=%b exp 1 %0d 1", hz.md_busy, hz.md_cnt, hz.stall, c); end
    end
    @(negedge clk);
    #1;
    checks++; if ({hz.md_busy, hz.md_cnt, hz.stall} !== 6'b0_0000_0) begin errors++; $display("FAIL mult_done got busy=%b cnt=%0d stall=%b exp 0 0 0", hz.md_busy, hz.md_cnt, hz.stall); end
    checks++; if (hz.stall_cnt !== 32'd6) begin errors++; $display("FAIL mult_stall_cnt got %0d exp 6", hz.stall_cnt); end
  endtask

  task automatic test_div_reset();
    do_reset();
    hz.md_D = 1'b1; hz.md_start_E = MD_DIV;
    for (int c = 10; c >= 8; c--) begin
      @(negedge clk);
      hz.md_start_E = MD_NONE;
      #1;
      checks++; if (hz.md_cnt !== 4'(c)) begin errors++; $display("FAIL div_cnt got %0d exp %0d", hz.md_cnt, c); end
    end
    reset = 1'b0;
    #1;
    checks++; if ({hz.md_busy, hz.md_cnt} !== 5'b0_0000) begin errors++; $display("FAIL div_async_rst got busy=%b cnt=%0d exp 0 0", hz.md_busy, hz.md_cnt); end
    checks++; if (hz.stall_cnt !== 32'd0) begin errors++; $display("FAIL div_rst_stall_cnt got %0d exp 0", hz.stall_cnt); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_md_err();
    do_reset();
    hz.md_start_E = 2'b11;
    @(negedge clk);
    hz.md_D = 1'b1;
    #1;
    checks++; if ({hz.md_busy, hz.stall} !== 2'b00) begin errors++; $display("FAIL md11_ignored got %b exp 00", {hz.md_busy, hz.stall}); end
    hz.md_D = 1'b0; hz.md_start_E = MD_MULT;
    @(negedge clk);
    #1;
    checks++; if ({hz.md_cnt, hz.md_err} !== {4'd5, 1'b0}) begin errors++; $display("FAIL err_pre got cnt=%0d err=%b exp 5 0", hz.md_cnt, hz.md_err); end
    @(negedge clk);
    hz.md_start_E = MD_NONE;
    #1;
    checks++; if ({hz.md_cnt, hz.md_err} !== {4'd4, 1'b1}) begin errors++; $display("FAIL err_set got cnt=%0d err=%b exp 4 1", hz.md_cnt, hz.md_err); end
    repeat (5) @(negedge clk);
    #1;
    checks++; if ({hz.md_busy, hz.md_err} !== 2'b01) begin errors++; $display("FAIL err_sticky got busy=%b err=%b exp 0 1", hz.md_busy, hz.md_err); end
    do_reset();
    #1;
    checks++; if (hz.md_err !== 1'b0) begin errors++; $display("FAIL err_clear got %b exp 0", hz.md_err); end
  endtask

  task automatic test_both_stalls();
    do_reset();
    hz.md_D = 1'b1; hz.md_start_E = MD_MULT;
    hz.rs_D = 5'd3; hz.use_rs_D = 1'b1; hz.a3_E = 5'd3; hz.tnew_E = TNEW_2;
    @(negedge clk);
    hz.md_start_E = MD_NONE;
    #1;
    checks++; if (hz.stall_cnt !== 32'd1) begin errors++; $display("FAIL both_once got %0d exp 1", hz.stall_cnt); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_data_stall_e();
    test_load_use();
    test_reg_zero();
    test_mult();
    test_div_reset();
    test_md_err();
    test_both_stalls();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
